e_m_pipe_reg: RTL and testbench
===============================

Name: e_m_pipe_reg

Overview:
- Pipeline register between the Execute stage (which hosts the multiply/divide unit) and the Memory stage of the P7 five-stage MIPS core.
- Selects the E-stage result from the ALU result or the HI/LO values of the multiply/divide unit (mfhi/mflo).
- Inserts bubbles while the multiply/divide unit is busy, and preserves PC/delay-slot information in bubbles so the CP0 EPC stays correct.
- Also honours M-stage hold, flushes on interrupt/exception, and counts multiply/divide stall cycles.

Parameters:
- WIDTH, 32, datapath width.
- EXC_W, 5, exception-code width.
- PC_RESET, 32'h0000_3000, m_pc value after reset.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  E stage holds a real instruction
- e_instr  in  WIDTH  E-stage instruction word
- e_pc  in  WIDTH  E-stage PC
- e_bd  in  1  E instruction is in a branch delay slot
- e_exc  in  EXC_W  exception code raised up to E (0 = none)
- e_alu  in  WIDTH  ALU result
- e_hi  in  WIDTH  HI from the multiply/divide unit
- e_lo  in  WIDTH  LO from the multiply/divide unit
- e_rt  in  WIDTH  forwarded rt value (store data)
- e_wr_addr  in  5  destination GPR
- e_we  in  1  GPR write enable
- e_res_sel  in  2  00 ALU, 01 HI, 10 LO, 11 ALU
- e_md_use  in  1  E instruction is mult/multu/div/divu/madd/msub/mthi/mtlo/mfhi/mflo
- md_busy  in  1  multiply/divide busy (includes start cycle)
- m_hold  in  1  M stage cannot accept (downstream wait)
- flush  in  1  interrupt/exception/eret flush of M input
- stall_e  out  1  freeze F/D/E stages
- m_valid  out  1  M holds a real instruction
- m_instr  out  WIDTH  registered instruction
- m_pc  out  WIDTH  registered PC
- m_bd  out  1  registered delay-slot flag
- m_exc  out  EXC_W  registered exception code
- m_result  out  WIDTH  selected E result
- m_rt  out  WIDTH  registered store data
- m_wr_addr  out  5  registered destination
- m_we  out  1  registered write enable
- md_stall_cnt  out  CNT_W  saturating count of multiply/divide stall cycles

Behaviour:
- md_stall (combinational) = e_valid & e_md_use & md_busy.
- stall_e (combinational) = md_stall | m_hold. It is not gated by flush; the flush controller owns upstream redirection.
- Register update on posedge clk uses the first matching priority below.
  1. reset: m_valid=0, m_instr=0, m_pc=PC_RESET, m_bd=0, m_exc=0, m_result=0, m_rt=0, m_wr_addr=0, m_we=0, md_stall_cnt=0.
  2. flush: bubble. m_valid=0, m_instr=0, m_pc=0, m_bd=0, m_exc=0, m_we=0, m_wr_addr=0, m_result=0, m_rt=0.
  3. m_hold: all M registers keep their values. A pending md_stall does not alter M.
  4. md_stall: bubble carrying position. m_valid=0, m_instr=0, m_we=0, m_wr_addr=0, m_exc=0, m_result=0, m_rt=0, m_pc=e_pc, m_bd=e_bd.
  5. Otherwise load: m_valid=e_valid, m_instr=e_instr, m_pc=e_pc, m_bd=e_bd, m_exc=e_exc, m_rt=e_rt, m_wr_addr=e_wr_addr.
     - m_we = e_we & e_valid & (e_exc==0).
     - m_result = e_hi if e_res_sel=01, e_lo if 10, else e_alu.
- md_stall_cnt increments on every cycle with md_stall=1 and reset=0, including cycles where flush or m_hold also apply. It saturates at all-ones.
- Latency: 1 cycle from E inputs to M outputs. HI/LO are sampled in the load cycle, i.e. the first cycle with md_busy=0 for mfhi/mflo.
- Non-md instructions are never stalled by md_busy.
- All outputs are registered except stall_e.

Test Plan:
- Reset: after reset, m_pc=32'h3000, m_valid=0, m_we=0, md_stall_cnt=0.
- Plain ALU op: e_pc=32'h3004, e_alu=32'h1234, e_we=1, e_res_sel=00, e_valid=1. Next cycle: m_result=32'h1234, m_we=1, m_pc=32'h3004, stall_e=0.
- mflo while busy: e_md_use=1, e_res_sel=10, md_busy=1 for 5 cycles, e_pc=32'h3010, e_bd=1.
  - During those cycles: stall_e=1, m_valid=0, m_pc=32'h3010, m_bd=1, md_stall_cnt reaches 5.
  - Cycle after busy drops with e_lo=32'h0000_0006: m_result=6, m_valid=1.
- Hold over stall: m_hold=1 together with md_stall=1 for 2 cycles → M registers unchanged, md_stall_cnt +2.
- Flush priority: flush=1 with m_hold=1 and a valid E instruction → m_valid=0, m_pc=0, m_we=0.
- Exception gating: e_exc=5'd12, e_we=1 → m_exc=12, m_we=0, m_valid=1.
- Counter saturation: force 65536 md_stall cycles → md_stall_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/e_m_pipe_reg.sv
// E/M pipeline register of the P7 MIPS core: selects the E-stage result, inserts
// position-preserving bubbles while the multiply/divide unit is busy, and counts those stalls.
module e_m_pipe_reg #(
    parameter int                 WIDTH    = 32,
    parameter int                 EXC_W    = 5,
    parameter logic [WIDTH-1:0]   PC_RESET = 32'h0000_3000,
    parameter int                 CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               e_valid,
    input  logic [WIDTH-1:0]   e_instr,
    input  logic [WIDTH-1:0]   e_pc,
    input  logic               e_bd,
    input  logic [EXC_W-1:0]   e_exc,
    input  logic [WIDTH-1:0]   e_alu,
    input  logic [WIDTH-1:0]   e_hi,
    input  logic [WIDTH-1:0]   e_lo,
    input  logic [WIDTH-1:0]   e_rt,
    input  logic [4:0]         e_wr_addr,
    input  logic               e_we,
    input  logic [1:0]         e_res_sel,
    input  logic               e_md_use,
    input  logic               md_busy,
    input  logic               m_hold,
    input  logic               flush,
    output logic               stall_e,
    output logic               m_valid,
    output logic [WIDTH-1:0]   m_instr,
    output logic [WIDTH-1:0]   m_pc,
    output logic               m_bd,
    output logic [EXC_W-1:0]   m_exc,
    output logic [WIDTH-1:0]   m_result,
    output logic [WIDTH-1:0]   m_rt,
    output logic [4:0]         m_wr_addr,
    output logic               m_we,
    output logic [CNT_W-1:0]   md_stall_cnt
);

    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [EXC_W-1:0] ZERO_EXC = {EXC_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // mfhi/mflo pick HI/LO; every other encoding passes the ALU result through
    function automatic logic [WIDTH-1:0] sel_result(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] alu,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo
    );
        case (sel)
            2'b01:   sel_result = hi;
            2'b10:   sel_result = lo;
            default: sel_result = alu;
        endcase
    endfunction

    logic             md_stall_s;
    logic [WIDTH-1:0] result_s;
    logic             we_s;

    // Stall detection and load-path result/write-enable selection
    always_comb begin
        md_stall_s = e_valid & e_md_use & md_busy;
        stall_e    = md_stall_s | m_hold;
        result_s   = sel_result(e_res_sel, e_alu, e_hi, e_lo);
        we_s       = e_we & e_valid & (e_exc == ZERO_EXC);
    end

    // M-stage registers: reset > flush > hold > md bubble > load
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid   <= 1'b0;
            m_instr   <= ZERO_W;
            m_pc      <= PC_RESET;
            m_bd      <= 1'b0;
            m_exc     <= ZERO_EXC;
            m_result  <= ZERO_W;
            m_rt      <= ZERO_W;
            m_wr_addr <= 5'd0;
            m_we      <= 1'b0;
        end else if (flush) begin
            m_valid   <= 1'b0;
            m_instr   <= ZERO_W;
            m_pc      <= ZERO_W;
            m_bd      <= 1'b0;
            m_exc     <= ZERO_EXC;
            m_result  <= ZERO_W;
            m_rt      <= ZERO_W;
            m_wr_addr <= 5'd0;
            m_we      <= 1'b0;
        end else if (m_hold) begin
            m_valid   <= m_valid;
            m_instr   <= m_instr;
            m_pc      <= m_pc;
            m_bd      <= m_bd;
            m_exc     <= m_exc;
            m_result  <= m_result;
            m_rt      <= m_rt;
            m_wr_addr <= m_wr_addr;
            m_we      <= m_we;
        end else if (md_stall_s) begin
            // bubble keeps PC/BD so an interrupt taken here still gets the right EPC
            m_valid   <= 1'b0;
            m_instr   <= ZERO_W;
            m_pc      <= e_pc;
            m_bd      <= e_bd;
            m_exc     <= ZERO_EXC;
            m_result  <= ZERO_W;
            m_rt      <= ZERO_W;
            m_wr_addr <= 5'd0;
            m_we      <= 1'b0;
        end else begin
            m_valid   <= e_valid;
            m_instr   <= e_instr;
            m_pc      <= e_pc;
            m_bd      <= e_bd;
            m_exc     <= e_exc;
            m_result  <= result_s;
            m_rt      <= e_rt;
            m_wr_addr <= e_wr_addr;
            m_we      <= we_s;
        end
    end

    // Saturating stall counter, counts regardless of flush/hold
    always_ff @(posedge clk) begin
        if (reset) begin
            md_stall_cnt <= {CNT_W{1'b0}};
        end else if (md_stall_s && (md_stall_cnt != CNT_MAX)) begin
            md_stall_cnt <= md_stall_cnt + CNT_ONE;
        end else begin
            md_stall_cnt <= md_stall_cnt;
        end
    end

endmodule

// File: tb/tb_e_m_pipe_reg.sv
// Scoreboard bench for e_m_pipe_reg: a behavioural model pushes expected M state
// per cycle, which is popped and compared one cycle later.
module tb_e_m_pipe_reg;

    logic        clk = 1'b0;
    logic        reset, e_valid, e_bd, e_we, e_md_use, md_busy, m_hold, flush;
    logic [31:0] e_instr, e_pc, e_alu, e_hi, e_lo, e_rt;
    logic [4:0]  e_exc, e_wr_addr;
    logic [1:0]  e_res_sel;
    logic        stall_e, m_valid, m_bd, m_we;
    logic [31:0] m_instr, m_pc, m_result, m_rt;
    logic [4:0]  m_exc, m_wr_addr;
    logic [15:0] md_stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [31:0] instr, pc, result, rt;
        logic        bd, we;
        logic [4:0]  exc, wr;
        logic [15:0] cnt;
    } exp_t;

    exp_t mdl;
    exp_t sb_q[$];

    e_m_pipe_reg dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_instr(e_instr), .e_pc(e_pc),
        .e_bd(e_bd), .e_exc(e_exc), .e_alu(e_alu), .e_hi(e_hi), .e_lo(e_lo), .e_rt(e_rt),
        .e_wr_addr(e_wr_addr), .e_we(e_we), .e_res_sel(e_res_sel), .e_md_use(e_md_use),
        .md_busy(md_busy), .m_hold(m_hold), .flush(flush), .stall_e(stall_e),
        .m_valid(m_valid), .m_instr(m_instr), .m_pc(m_pc), .m_bd(m_bd), .m_exc(m_exc),
        .m_result(m_result), .m_rt(m_rt), .m_wr_addr(m_wr_addr), .m_we(m_we),
        .md_stall_cnt(md_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        exp_t  nx;
        logic  mds;
        #1;
        mds = e_valid & e_md_use & md_busy;
        check_val("stall_e", {31'd0, stall_e}, {31'd0, mds | m_hold});
        nx = mdl;
        if (reset) begin
            nx.valid = 1'b0; nx.instr = 32'd0; nx.pc = 32'h0000_3000; nx.bd = 1'b0;
            nx.exc = 5'd0; nx.result = 32'd0; nx.rt = 32'd0; nx.wr = 5'd0; nx.we = 1'b0;
            nx.cnt = 16'd0;
        end else begin
            if (mds && nx.cnt != 16'hFFFF) nx.cnt = nx.cnt + 16'd1;
            if (flush || (!m_hold && mds)) begin
                nx.valid = 1'b0; nx.instr = 32'd0; nx.exc = 5'd0; nx.result = 32'd0;
                nx.rt = 32'd0; nx.wr = 5'd0; nx.we = 1'b0;
                nx.pc = flush ? 32'd0 : e_pc;
                nx.bd = flush ? 1'b0 : e_bd;
            end else if (!m_hold) begin
                nx.valid = e_valid; nx.instr = e_instr; nx.pc = e_pc; nx.bd = e_bd;
                nx.exc = e_exc; nx.rt = e_rt; nx.wr = e_wr_addr;
                nx.we = e_we && e_valid && (e_exc == 5'd0);
                nx.result = (e_res_sel == 2'b01) ? e_hi : (e_res_sel == 2'b10) ? e_lo : e_alu;
            end
        end
        mdl = nx;
        sb_q.push_back(nx);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            nx = sb_q.pop_front();
            check_val("m_valid", {31'd0, m_valid}, {31'd0, nx.valid});
            check_val("m_instr", m_instr, nx.instr);
            check_val("m_pc", m_pc, nx.pc);
            check_val("m_bd", {31'd0, m_bd}, {31'd0, nx.bd});
            check_val("m_exc", {27'd0, m_exc}, {27'd0, nx.exc});
            check_val("m_result", m_result, nx.result);
            check_val("m_rt", m_rt, nx.rt);
            check_val("m_wr_addr", {27'd0, m_wr_addr}, {27'd0, nx.wr});
            check_val("m_we", {31'd0, m_we}, {31'd0, nx.we});
            check_val("md_stall_cnt", {16'd0, md_stall_cnt}, {16'd0, nx.cnt});
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; e_valid = 1'b0; e_bd = 1'b0; e_we = 1'b0; e_md_use = 1'b0;
        md_busy = 1'b0; m_hold = 1'b0; flush = 1'b0; e_instr = 32'd0; e_pc = 32'd0;
        e_alu = 32'd0; e_hi = 32'd0; e_lo = 32'd0; e_rt = 32'd0; e_exc = 5'd0;
        e_wr_addr = 5'd0; e_res_sel = 2'b00;
    endtask

    task automatic alu_op(input logic [31:0] pc, input logic [31:0] alu);
        idle_inputs();
        e_valid = 1'b1; e_pc = pc; e_alu = alu; e_we = 1'b1; e_wr_addr = 5'd8;
        e_instr = 32'h0109_4020; e_rt = 32'hAAAA_5555;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check_val("rst_pc", m_pc, 32'h0000_3000);
        check_val("rst_cnt", {16'd0, md_stall_cnt}, 32'd0);

        // plain ALU op
        alu_op(32'h0000_3004, 32'h0000_1234);
        step();
        check_val("alu_result", m_result, 32'h0000_1234);
        check_val("alu_we", {31'd0, m_we}, 32'd1);

        // mflo while busy for 5 cycles, then HI/LO sampled in load cycle
        idle_inputs();
        e_valid = 1'b1; e_md_use = 1'b1; e_res_sel = 2'b10; md_busy = 1'b1;
        e_pc = 32'h0000_3010; e_bd = 1'b1; e_we = 1'b1; e_wr_addr = 5'd9;
        e_instr = 32'h0000_4812; e_lo = 32'hDEAD_0000;
        for (int i = 0; i < 5; i++) step();
        check_val("busy_pc", m_pc, 32'h0000_3010);
        check_val("busy_bd", {31'd0, m_bd}, 32'd1);
        check_val("busy_valid", {31'd0, m_valid}, 32'd0);
        check_val("busy_cnt", {16'd0, md_stall_cnt}, 32'd5);
        md_busy = 1'b0; e_lo = 32'h0000_0006;
        step();
        check_val("mflo_result", m_result, 32'h0000_0006);
        check_val("mflo_valid", {31'd0, m_valid}, 32'd1);

        // non-md op is never stalled by md_busy
        alu_op(32'h0000_3018, 32'h0000_0077);
        md_busy = 1'b1;
        step();
        check_val("nonmd_valid", {31'd0, m_valid}, 32'd1);

        // hold over a pending md stall
        idle_inputs();
        e_valid = 1'b1; e_md_use = 1'b1; md_busy = 1'b1; m_hold = 1'b1;
        e_pc = 32'h0000_3020; e_res_sel = 2'b01;
        step();
        step();
        check_val("hold_pc", m_pc, 32'h0000_3018);
        check_val("hold_cnt", {16'd0, md_stall_cnt}, 32'd7);

        // flush beats hold
        alu_op(32'h0000_3024, 32'h0000_0055);
        m_hold = 1'b1; flush = 1'b1;
        step();
        check_val("flush_pc", m_pc, 32'd0);
        check_val("flush_valid", {31'd0, m_valid}, 32'd0);

        // exception gates write enable
        alu_op(32'h0000_3028, 32'h0000_0099);
        e_exc = 5'd12;
        step();
        check_val("exc_code", {27'd0, m_exc}, 32'd12);
        check_val("exc_we", {31'd0, m_we}, 32'd0);
        check_val("exc_valid", {31'd0, m_valid}, 32'd1);

        // random mix
        for (int i = 0; i < 300; i++) begin
            e_valid = 1'($urandom_range(0, 3) != 0);
            e_instr = $urandom; e_pc = $urandom; e_bd = 1'($urandom);
            e_exc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            e_alu = $urandom; e_hi = $urandom; e_lo = $urandom; e_rt = $urandom;
            e_wr_addr = 5'($urandom); e_we = 1'($urandom); e_res_sel = 2'($urandom);
            e_md_use = 1'($urandom); md_busy = 1'($urandom);
            m_hold = 1'($urandom_range(0, 4) == 0);
            flush  = 1'($urandom_range(0, 7) == 0);
            reset  = 1'($urandom_range(0, 63) == 0);
            step();
        end

        // saturation
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        e_valid = 1'b1; e_md_use = 1'b1; md_busy = 1'b1; e_pc = 32'h0000_3040;
        for (int i = 0; i < 65540; i++) step();
        check_val("sat_cnt", {16'd0, md_stall_cnt}, 32'h0000_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
